up_state_mgr: RTL and testbench
===============================

# up_state_mgr

Micro-processor state manager: the controlling end of the core's boot/pause handshake. After reset it loads the program image from a byte stream into memory through a dedicated boot write port, then releases the core by asserting booted. While running it requests a core pause on a debug toggle or a core halt, and waits for the core's paused acknowledge. It resumes the core on the next toggle. It sits at top level beside the core and memory; the memory mux selects the boot port while booted is low.

## Interface
Parameters:
- BOOT_WORDS, default 32768: number of 16-bit words loaded at boot, written to word addresses 0..BOOT_WORDS-1. Legal range 1..32768.

Ports:
- i_clk  in  1  system clock. The block has one clock.
- i_rstn  in  1  reset, synchronous and active-low.
- i_bootData  in  8  boot image byte. Bytes arrive high byte first.
- i_bootValid  in  1  i_bootData is valid.
- o_bootReady  out  1  the block accepts a byte this cycle.
- o_bootMemAddr  out  16  boot write word address, formed as {1'b0, 15-bit word counter}.
- o_bootMemData  out  16  boot write data.
- o_bootMemWr  out  1  boot write strobe, a one-cycle pulse.
- o_smIsBooted  out  1  to core: image loaded, core may run.
- o_smStartPause  out  1  to core: request pause or hold the core paused.
- i_smNowPaused  in  1  from core: core is paused.
- i_coreHlt  in  1  from core: a HLT instruction is in execute.
- i_dbgToggle  in  1  debug pause/resume level. It is already synchronous to i_clk.
- o_state  out  2  current state: BOOT=0, RUN=1, PAUSING=2, PAUSED=3.

## Operation
- States and what drives each:
  - BOOT: o_bootReady = ~loadDone.
  - RUN: normal execution.
  - PAUSING: o_smStartPause=1 while waiting for the core to acknowledge.
  - PAUSED: o_smStartPause stays 1, because the core stays paused only while the request is held.
- o_smIsBooted = (state != BOOT).
- Byte handshake:
  - A byte transfers on any cycle with i_bootValid & o_bootReady.
  - A phase bit selects high or low byte. The high byte is held in a register.
  - When the low byte is accepted, the next cycle issues o_bootMemWr=1 with o_bootMemData={hi,lo} and o_bootMemAddr=wordCnt. wordCnt then increments.
- Load completion:
  - Accepting the low byte of word BOOT_WORDS-1 sets loadDone, which drops o_bootReady the following cycle.
  - After the final write pulse, state moves BOOT -> RUN.
- The toggle event is a rising edge of i_dbgToggle. It is detected with a one-cycle history register, which tracks the input in every state.
- Transitions:
  - RUN -> PAUSING on a toggle edge or on i_coreHlt.
  - PAUSING -> PAUSED when i_smNowPaused=1.
  - PAUSED -> RUN on a toggle edge. o_smStartPause drops in the same cycle that RUN is entered.
- Ignored events:
  - Toggle edges in BOOT and PAUSING are ignored, not queued.
  - i_coreHlt in BOOT, PAUSING and PAUSED is ignored.
- Simultaneous events: in RUN, a toggle edge and i_coreHlt together cause a single transition to PAUSING.
- Bytes offered outside BOOT are not accepted (o_bootReady=0).

## Timing
- Reset (i_rstn=0 at a clock edge) forces the following, from any state and mid-load included:
  - state=BOOT.
  - wordCnt=0, phase=0, loadDone=0.
  - o_bootMemWr=0, o_bootMemAddr=0, o_bootMemData=0.
  - o_smIsBooted=0, o_smStartPause=0.
  - toggle history = 0.
- o_bootReady is 1 in the first cycle after reset is released.
- Latency from low-byte acceptance to the write pulse is exactly 1 cycle.
- Maximum byte rate is one byte per cycle. A word therefore takes 2 cycles minimum, and writes can occur every other cycle.
- o_smIsBooted rises the cycle after the final o_bootMemWr pulse.
- A toggle edge or i_coreHlt in cycle N gives o_smStartPause=1 in cycle N+1, since state and outputs are registered.
- The core acknowledges one cycle after the request. PAUSED is reached at the edge where i_smNowPaused is first sampled high.
- Word address wrap cannot occur: wordCnt saturates, and loading stops at BOOT_WORDS.

## Structure
- A shared package holds:
  - the state encoding constants BOOT/RUN/PAUSING/PAUSED;
  - the boot port width constants (address 16, data 16, byte 8).
- One sub-module, boot_loader, is natural. It contains the byte handshake, the byte-to-word assembly, wordCnt/loadDone and the write port, and exports a done signal.
- The top level holds the state machine, the toggle edge detect and the core handshake.

## Test plan
- Boot load, BOOT_WORDS=4, stream 0x12,0x34,0xAB,0xCD,0x00,0x01,0xFF,0xEE back-to-back:
  - writes addr0=0x1234, addr1=0xABCD, addr2=0x0001, addr3=0xFFEE, each a single pulse;
  - o_smIsBooted rises the cycle after the addr3 write;
  - o_bootReady=0 after that.
- Boot load with i_bootValid gapped (one byte every 3 cycles): the same writes and data; no extra or duplicate pulses.
- Debug pause and resume in RUN, with the core model acknowledging 1 cycle late:
  - toggle edge -> o_smStartPause=1 next cycle, state=PAUSING;
  - i_smNowPaused=1 -> state=PAUSED, o_smStartPause held;
  - second toggle edge -> state=RUN, o_smStartPause=0.
- Halt: i_coreHlt=1 in RUN -> PAUSING -> PAUSED. A toggle edge in PAUSING is ignored, and the state stays PAUSING until the acknowledge.
- Reset mid-load after 3 bytes:
  - all outputs return to their reset values;
  - reloading 8 bytes produces writes starting again at addr0.
- Idle toggle and halt: toggle edges and i_coreHlt during BOOT leave state=BOOT and o_smStartPause=0; i_bootValid asserted in RUN causes no write.

Source files
------------

// File: rtl/up_state_mgr_pkg.sv
// rtl/up_state_mgr_pkg.sv - state encoding and boot port widths for the state manager
package up_state_mgr_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    PAUSING = 2'd2,
    PAUSED  = 2'd3
  } sm_state_t;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = ADDR_W - 1;

endpackage

// File: rtl/up_state_mgr_if.sv
// rtl/up_state_mgr_if.sv - boot stream, boot write port and core handshake bundle
interface up_state_mgr_if;
  import up_state_mgr_pkg::*;

  logic [BYTE_W-1:0] i_bootData;
  logic              i_bootValid;
  logic              o_bootReady;
  logic [ADDR_W-1:0] o_bootMemAddr;
  logic [DATA_W-1:0] o_bootMemData;
  logic              o_bootMemWr;
  logic              o_smIsBooted;
  logic              o_smStartPause;
  logic              i_smNowPaused;
  logic              i_coreHlt;
  logic              i_dbgToggle;
  logic [1:0]        o_state;

  modport master (
    input  i_bootData, i_bootValid, i_smNowPaused, i_coreHlt, i_dbgToggle,
    output o_bootReady, o_bootMemAddr, o_bootMemData, o_bootMemWr,
           o_smIsBooted, o_smStartPause, o_state
  );

  modport slave (
    output i_bootData, i_bootValid, i_smNowPaused, i_coreHlt, i_dbgToggle,
    input  o_bootReady, o_bootMemAddr, o_bootMemData, o_bootMemWr,
           o_smIsBooted, o_smStartPause, o_state
  );

endinterface

// File: rtl/up_state_mgr_boot_loader.sv
// rtl/up_state_mgr_boot_loader.sv - byte stream to 16-bit word writes for the boot image
module up_state_mgr_boot_loader
  import up_state_mgr_pkg::*;
#(
  parameter int BOOT_WORDS = 32768
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr,
  output logic              done
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BOOT_WORDS - 1);

  logic [CNT_W-1:0]  word_cnt;
  logic [BYTE_W-1:0] hi_byte;
  logic              phase;
  logic              load_done;
  logic              accept;

  assign byte_ready = en & ~load_done;
  assign accept     = byte_valid & byte_ready;
  // load_done is set on the same edge that raises the final write pulse
  assign done       = load_done & mem_wr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      word_cnt  <= '0;
      hi_byte   <= '0;
      phase     <= 1'b0;
      load_done <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      mem_wr <= 1'b0;
      if (accept) begin
        if (!phase) begin
          hi_byte <= byte_data;
          phase   <= 1'b1;
        end else begin
          phase    <= 1'b0;
          mem_wr   <= 1'b1;
          mem_data <= {hi_byte, byte_data};
          mem_addr <= {1'b0, word_cnt};
          // saturate on the last word so the address never wraps
          if (word_cnt == LAST_WORD) begin
            load_done <= 1'b1;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/up_state_mgr.sv
// rtl/up_state_mgr.sv - boot/pause controller: loads the image, then gates core run/pause
module up_state_mgr
  import up_state_mgr_pkg::*;
#(
  parameter int BOOT_WORDS = 32768
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  up_state_mgr_if.master bus
);

  sm_state_t state;
  logic      toggle_q;
  logic      toggle_edge;
  logic      start_pause;
  logic      booted;
  logic      boot_done;

  assign toggle_edge        = bus.i_dbgToggle & ~toggle_q;
  assign bus.o_state        = state;
  assign bus.o_smStartPause = start_pause;
  assign bus.o_smIsBooted   = booted;

  up_state_mgr_boot_loader #(
    .BOOT_WORDS (BOOT_WORDS)
  ) u_boot_loader (
    .clk        (i_clk),
    .rstn       (i_rstn),
    .en         (state == BOOT),
    .byte_data  (bus.i_bootData),
    .byte_valid (bus.i_bootValid),
    .byte_ready (bus.o_bootReady),
    .mem_addr   (bus.o_bootMemAddr),
    .mem_data   (bus.o_bootMemData),
    .mem_wr     (bus.o_bootMemWr),
    .done       (boot_done)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state       <= BOOT;
      start_pause <= 1'b0;
      booted      <= 1'b0;
      toggle_q    <= 1'b0;
    end else begin
      toggle_q <= bus.i_dbgToggle;
      case (state)
        BOOT: begin
          if (boot_done) begin
            state  <= RUN;
            booted <= 1'b1;
          end
        end
        RUN: begin
          if (toggle_edge | bus.i_coreHlt) begin
            state       <= PAUSING;
            start_pause <= 1'b1;
          end
        end
        PAUSING: begin
          if (bus.i_smNowPaused) begin
            state <= PAUSED;
          end
        end
        PAUSED: begin
          // the core stays paused only while the request is held
          if (toggle_edge) begin
            state       <= RUN;
            start_pause <= 1'b0;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_up_state_mgr.sv
// tb/tb_up_state_mgr.sv - randomized self-checking bench for up_state_mgr
module tb_up_state_mgr;

  localparam int BW        = 4;
  localparam int S_BOOT    = 0;
  localparam int S_RUN     = 1;
  localparam int S_PAUSING = 2;
  localparam int S_PAUSED  = 3;

  logic i_clk  = 1'b0;
  logic i_rstn = 1'b0;

  up_state_mgr_if bus ();

  up_state_mgr #(.BOOT_WORDS(BW)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  int          n_checks    = 0;
  int          n_fail      = 0;
  int          cyc         = 0;
  int          last_wr_cyc = -1;
  int          rise_cyc    = -1;
  logic        prev_booted = 1'b0;
  logic [31:0] wq[$];
  logic [7:0]  bq[2*BW];
  int          m_st;
  bit          m_tog;
  bit          ack_q;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (bus.o_bootMemWr) begin
      wq.push_back({bus.o_bootMemAddr, bus.o_bootMemData});
      last_wr_cyc = cyc;
    end
    if (bus.o_smIsBooted && !prev_booted) rise_cyc = cyc;
    prev_booted = bus.o_smIsBooted;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_boot_idle();
    check("boot_state", 32'(bus.o_state), S_BOOT);
    check("boot_pause", 32'(bus.o_smStartPause), 0);
  endtask

  task automatic do_reset();
    i_rstn            = 1'b0;
    bus.i_bootValid   = 1'b0;
    bus.i_dbgToggle   = 1'($urandom_range(0, 1));
    bus.i_coreHlt     = 1'b0;
    bus.i_smNowPaused = 1'b0;
    tick();
    check("rst_state",  32'(bus.o_state), S_BOOT);
    check("rst_booted", 32'(bus.o_smIsBooted), 0);
    check("rst_pause",  32'(bus.o_smStartPause), 0);
    check("rst_wr",     32'(bus.o_bootMemWr), 0);
    check("rst_addr",   32'(bus.o_bootMemAddr), 0);
    check("rst_data",   32'(bus.o_bootMemData), 0);
    tick();
    i_rstn = 1'b1;
    tick();
    check("rel_ready", 32'(bus.o_bootReady), 1);
    check("rel_state", 32'(bus.o_state), S_BOOT);
    wq.delete();
    last_wr_cyc = -1;
    rise_cyc    = -1;
  endtask

  task automatic fill_bytes(input bit fixed);
    logic [7:0] tbl [8];
    tbl = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hEE};
    for (int i = 0; i < 2*BW; i++) bq[i] = fixed ? tbl[i] : 8'($urandom);
  endtask

  // gap < 0 selects a random 0..3 idle cycles before each byte
  task automatic feed(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int g;
      bit acc;
      int t;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int k = 0; k < g; k++) begin
        bus.i_bootValid = 1'b0;
        bus.i_bootData  = 8'($urandom);
        bus.i_dbgToggle = 1'($urandom_range(0, 1));
        bus.i_coreHlt   = 1'($urandom_range(0, 1));
        tick();
        check_boot_idle();
      end
      bus.i_bootValid = 1'b1;
      bus.i_bootData  = bq[i];
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 8) begin
        acc = bus.o_bootReady;
        bus.i_dbgToggle = 1'($urandom_range(0, 1));
        bus.i_coreHlt   = 1'($urandom_range(0, 1));
        tick();
        check_boot_idle();
        t++;
      end
      if (!acc) check("feed_accept_timeout", 0, 1);
    end
    bus.i_bootValid = 1'b0;
    bus.i_coreHlt   = 1'b0;
  endtask

  task automatic boot_load(input bit fixed, input int gap);
    fill_bytes(fixed);
    feed(2*BW, gap);
    for (int t = 0; t < 10 && !bus.o_smIsBooted; t++) tick();
    check("booted_up", 32'(bus.o_smIsBooted), 1);
    @(negedge i_clk);
    #1;
    check("booted_after_last_wr", 32'(rise_cyc - last_wr_cyc), 1);
    check("wr_count", 32'(wq.size()), BW);
    for (int w = 0; w < BW && w < wq.size(); w++)
      check($sformatf("wr_word%0d", w), wq[w], {16'(w), bq[2*w], bq[2*w+1]});
    check("ready_after_boot", 32'(bus.o_bootReady), 0);
    check("state_after_boot", 32'(bus.o_state), S_RUN);
    wq.delete();
    @(posedge i_clk);
    #1;
    m_st  = S_RUN;
    m_tog = bus.i_dbgToggle;
    ack_q = 1'b0;
  endtask

  // one cycle in the post-boot phase; core model acks one cycle after seeing the request
  task automatic step(input bit tog, input bit hlt, input bit vld);
    bit edge_ev;
    bit ack_next;
    bus.i_dbgToggle   = tog;
    bus.i_coreHlt     = hlt;
    bus.i_bootValid   = vld;
    bus.i_bootData    = 8'($urandom);
    bus.i_smNowPaused = ack_q;
    edge_ev  = tog && !m_tog;
    m_tog    = tog;
    ack_next = (m_st == S_PAUSING) || (m_st == S_PAUSED);
    if (m_st == S_RUN && (edge_ev || hlt)) m_st = S_PAUSING;
    else if (m_st == S_PAUSING && ack_q)   m_st = S_PAUSED;
    else if (m_st == S_PAUSED && edge_ev)  m_st = S_RUN;
    ack_q = ack_next;
    tick();
    check("run_state",  32'(bus.o_state), 32'(m_st));
    check("run_pause",  32'(bus.o_smStartPause), 32'(m_st == S_PAUSING || m_st == S_PAUSED));
    check("run_booted", 32'(bus.o_smIsBooted), 1);
    check("run_no_wr",  32'(bus.o_bootMemWr), 0);
    check("run_ready",  32'(bus.o_bootReady), 0);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      bit tog;
      tog = ($urandom_range(0, 3) == 0) ? !m_tog : m_tog;
      step(tog, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    bus.i_bootData    = '0;
    bus.i_bootValid   = 1'b0;
    bus.i_smNowPaused = 1'b0;
    bus.i_coreHlt     = 1'b0;
    bus.i_dbgToggle   = 1'b0;

    do_reset();
    boot_load(1'b1, 0);

    // debug pause then resume
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);

    // halt, with a toggle edge while still pausing and a halt while paused
    step(1, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    step(1, 0, 1);

    random_run(150);

    do_reset();
    fill_bytes(1'b0);
    feed(3, 0);
    do_reset();
    boot_load(1'b0, 2);
    random_run(100);

    do_reset();
    boot_load(1'b0, -1);
    random_run(100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
